// File: rtl/sdram_slot_scheduler_if.sv
// SDRAM controller port as seen by the slot scheduler.
// master = scheduler side (issues commands), slave = controller side.
interface sdram_slot_scheduler_if;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_do;
  logic [15:0] sdram_di;
  logic        sdram_lb;
  logic        sdram_ub;
  logic        sdram_rd;
  logic        sdram_wr;
  logic        sdram_refresh;
  logic        sdram_busy;

  modport master (
    output sdram_addr, sdram_do, sdram_lb, sdram_ub,
           sdram_rd, sdram_wr, sdram_refresh,
    input  sdram_di, sdram_busy
  );

  modport slave (
    input  sdram_addr, sdram_do, sdram_lb, sdram_ub,
           sdram_rd, sdram_wr, sdram_refresh,
    output sdram_di, sdram_busy
  );
endinterface

// File: rtl/sdram_slot_scheduler.sv
// Shares one SDRAM port between bus ramdisk cycles, disk accesses and refresh.
// Define DISK_ANYSLOT_EN to let disk commands issue without waiting for access_slot.
module sdram_slot_scheduler #(
  parameter int REFRESH_PERIOD = 360,
  parameter int URGENT_FACTOR  = 2,
  parameter int VU_AW          = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   access_slot,
  input  logic                   vu_rd,
  input  logic                   vu_wr,
  input  logic [VU_AW-1:0]       vu_addr,
  input  logic [7:0]             vu_wdata,
  output logic [7:0]             vu_rdata,
  output logic                   vu_rdata_valid,
  output logic                   vu_overrun,
  input  logic                   disk_rd,
  input  logic                   disk_wr,
  input  logic [22:0]            disk_addr,
  input  logic [7:0]             disk_wdata,
  output logic [7:0]             disk_rdata,
  output logic                   disk_busy,
  sdram_slot_scheduler_if.master sdram
);

  localparam int URGENT_AGE = URGENT_FACTOR * REFRESH_PERIOD;
  localparam int CNT_W      = $clog2(REFRESH_PERIOD);
  localparam int AGE_W      = $clog2(URGENT_AGE + 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_BUS, OWN_DISK, OWN_REF}     owner_t;

  state_t state, state_nxt;
  owner_t owner, grant;
  logic   grant_valid;

  logic             vu_pend, vu_pend_wr;
  logic [VU_AW-1:0] vu_pend_addr;
  logic [7:0]       vu_pend_data;
  logic             vu_req, vu_accept;

  logic        disk_pend, disk_pend_wr;
  logic [22:0] disk_pend_addr;
  logic [7:0]  disk_pend_data;
  logic        disk_accept;

  logic [CNT_W-1:0] ref_cnt;
  logic [AGE_W-1:0] ref_age;
  logic             ref_pending, ref_wrap, ref_urgent;

  logic        cmd_wr;
  logic [22:0] cmd_addr;
  logic [7:0]  cmd_data;

  logic       issue, done_cycle, rd_capture, disk_slot_ok;
  logic [7:0] rd_byte;

  assign vu_req      = vu_rd | vu_wr;
  assign vu_accept   = vu_req & ~vu_pend;
  assign disk_accept = (disk_rd | disk_wr) & ~disk_busy;
  assign ref_wrap    = (ref_cnt == CNT_W'(REFRESH_PERIOD - 1));
  assign ref_urgent  = ref_pending && (ref_age >= AGE_W'(URGENT_AGE));

`ifdef DISK_ANYSLOT_EN
  assign disk_slot_ok = 1'b1;
`else
  assign disk_slot_ok = access_slot;
`endif

  assign issue      = (state == S_IDLE) && grant_valid;
  assign done_cycle = (state == S_DONE);
  assign rd_capture = (state == S_WAIT) && !sdram.sdram_busy && !cmd_wr && (owner != OWN_REF);
  assign rd_byte    = cmd_addr[0] ? sdram.sdram_di[15:8] : sdram.sdram_di[7:0];

  // Bus requests bypass the slot so an idle scheduler issues them the next cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant_valid = 1'b1;
    grant       = OWN_BUS;
    if (vu_pend || vu_accept)           grant = OWN_BUS;
    else if (ref_urgent)                grant = OWN_REF;
    else if (disk_pend && disk_slot_ok) grant = OWN_DISK;
    else if (ref_pending && access_slot) grant = OWN_REF;
    else                                grant_valid = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_valid)        state_nxt = S_CMD;
      S_CMD:   if (sdram.sdram_busy)   state_nxt = S_WAIT;
      S_WAIT:  if (!sdram.sdram_busy)  state_nxt = S_DONE;
      S_DONE:                          state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sdram.sdram_rd      = 1'b0;
    sdram.sdram_wr      = 1'b0;
    sdram.sdram_refresh = 1'b0;
    sdram.sdram_addr    = '0;
    sdram.sdram_lb      = 1'b0;
    sdram.sdram_ub      = 1'b0;
    sdram.sdram_do      = '0;
    if ((state == S_CMD || state == S_WAIT) && owner != OWN_REF) begin
      sdram.sdram_addr = cmd_addr[22:1];
      sdram.sdram_lb   = ~cmd_addr[0];
      sdram.sdram_ub   = cmd_addr[0];
      sdram.sdram_do   = {cmd_data, cmd_data};
    end
    if (state == S_CMD) begin
      sdram.sdram_rd      = (owner != OWN_REF) && !cmd_wr;
      sdram.sdram_wr      = (owner != OWN_REF) && cmd_wr;
      sdram.sdram_refresh = (owner == OWN_REF);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWN_BUS;
      cmd_wr   <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
    end else if (issue) begin
      owner <= grant;
      case (grant)
        OWN_BUS: begin
          if (vu_pend) begin
            cmd_wr   <= vu_pend_wr;
            cmd_addr <= 23'(vu_pend_addr);
            cmd_data <= vu_pend_data;
          end else begin
            cmd_wr   <= vu_wr;
            cmd_addr <= 23'(vu_addr);
            cmd_data <= vu_wdata;
          end
        end
        OWN_DISK: begin
          cmd_wr   <= disk_pend_wr;
          cmd_addr <= disk_pend_addr;
          cmd_data <= disk_pend_data;
        end
        default: begin
          cmd_wr   <= 1'b0;
          cmd_addr <= '0;
          cmd_data <= '0;
        end
      endcase
    end
  end

  // The bus slot stays full while its command is in flight; it empties at DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vu_pend      <= 1'b0;
      vu_pend_wr   <= 1'b0;
      vu_pend_addr <= '0;
      vu_pend_data <= '0;
      vu_overrun   <= 1'b0;
    end else begin
      if (vu_accept) begin
        vu_pend      <= 1'b1;
        vu_pend_wr   <= vu_wr;
        vu_pend_addr <= vu_addr;
        vu_pend_data <= vu_wdata;
      end else if (done_cycle && owner == OWN_BUS) begin
        vu_pend <= 1'b0;
      end
      if (vu_req && vu_pend) vu_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disk_pend      <= 1'b0;
      disk_busy      <= 1'b0;
      disk_pend_wr   <= 1'b0;
      disk_pend_addr <= '0;
      disk_pend_data <= '0;
    end else if (disk_accept) begin
      disk_pend      <= 1'b1;
      disk_busy      <= 1'b1;
      disk_pend_wr   <= disk_wr;
      disk_pend_addr <= disk_addr;
      disk_pend_data <= disk_wdata;
    end else begin
      if (issue && grant == OWN_DISK)      disk_pend <= 1'b0;
      if (done_cycle && owner == OWN_DISK) disk_busy <= 1'b0;
    end
  end

  // A wrap landing on the refresh DONE cycle starts a fresh request rather than being lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_age     <= '0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (done_cycle && owner == OWN_REF) begin
        ref_pending <= ref_wrap;
        ref_age     <= '0;
      end else begin
        if (ref_wrap) ref_pending <= 1'b1;
        if (ref_pending && ref_age < AGE_W'(URGENT_AGE)) ref_age <= ref_age + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vu_rdata       <= '0;
      vu_rdata_valid <= 1'b0;
      disk_rdata     <= '0;
    end else begin
      vu_rdata_valid <= rd_capture && owner == OWN_BUS;
      if (rd_capture && owner == OWN_BUS)  vu_rdata   <= rd_byte;
      if (rd_capture && owner == OWN_DISK) disk_rdata <= rd_byte;
    end
  end

endmodule
